// File: rtl/perf_counter_bank.sv
// Performance-counter bank: one free-running cycle counter plus NUM_CH event channels,
// a run-control FSM and a snapshot bank. Define PERF_WRAP_EN for wrapping counters (default saturates).

module perf_cnt_lane #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_d_o,
  output logic [W-1:0] cnt_q_o,
  output logic         ovf_o
);
  logic [W-1:0] cnt_d, cnt_q;
  logic         ovf_d, ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (cnt_q == {W{1'b1}}) begin
        ovf_d = 1'b1;
`ifdef PERF_WRAP_EN
        cnt_d = '0;
`else
        cnt_d = cnt_q;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_d_o = cnt_d;
  assign cnt_q_o = cnt_q;
  assign ovf_o   = ovf_q;
endmodule

module perf_counter_bank #(
  parameter  int NUM_CH     = 4,
  parameter  int CNT_WIDTH  = 32,
  parameter  int MAX_CYCLES = 200000,
  localparam int SEL_W      = $clog2(NUM_CH + 1)
) (
  input  logic                 input_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 hlt,
  input  logic [NUM_CH-1:0]    event_vec,
  input  logic                 snap_req,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 snap_valid,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [NUM_CH:0]      overflow
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_TIMEOUT} state_t;

  // Compared at 64 bits so a limit beyond the counter range simply never fires.
  localparam logic [63:0] WD_LAST = 64'(MAX_CYCLES) - 64'd1;

  state_t                         state_q;
  logic [NUM_CH:0][CNT_WIDTH-1:0] cnt_d, cnt_q, snap_q;
  logic [NUM_CH:0]                inc;
  logic                           snap_valid_q;
  logic                           run, wd_hit, capture;

  assign run     = (state_q == S_RUN);
  assign inc     = {event_vec & {NUM_CH{run}}, run};
  assign wd_hit  = (64'(cnt_q[0]) == WD_LAST);
  // Explicit requests and both exits from RUN capture the post-increment values.
  assign capture = run && (snap_req || hlt || wd_hit);

  for (genvar g = 0; g <= NUM_CH; g++) begin : g_lane
    perf_cnt_lane #(.W(CNT_WIDTH)) u_lane (
      .clk_i   (input_clk),
      .rst_i   (rst),
      .clr_i   (clear),
      .inc_i   (inc[g]),
      .cnt_d_o (cnt_d[g]),
      .cnt_q_o (cnt_q[g]),
      .ovf_o   (overflow[g])
    );
  end

  always_ff @(posedge input_clk) begin
    if (rst || clear) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= capture;
      if (capture) snap_q <= cnt_d;
      case (state_q)
        S_IDLE:  if (start) state_q <= S_RUN;
        S_RUN: begin
          if (hlt)         state_q <= S_HALTED;
          else if (wd_hit) state_q <= S_TIMEOUT;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_sel) <= NUM_CH) rd_data = snap_q[rd_sel];
  end

  assign snap_valid = snap_valid_q;
  assign running    = (state_q == S_RUN);
  assign done       = (state_q == S_HALTED);
  assign timeout    = (state_q == S_TIMEOUT);
endmodule
